// File: rtl/mul_seq_lanes.sv
// Multi-lane sequential multiplier. Each OP_W-bit operand is split into
// CHUNK_W-bit chunks and one shifted chunk product per lane is accumulated
// per cycle. Signs are stripped at acceptance and reapplied to the final sum.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: when every lane has a zero
// operand at acceptance the FSM jumps straight to DONE with a zero product.
//
// state  | meaning
// -------+--------------------------------------------------------
// S_IDLE | ready for operands, last product held on the output
// S_CALC | accumulating chunk products, one (i,j) pair per cycle
// S_DONE | product valid, waiting for out_ready
module mul_seq_lanes #(
    parameter int LANES   = 2,
    parameter int OP_W    = 16,
    parameter int CHUNK_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic [LANES*OP_W-1:0]     op_a,
    input  logic [LANES*OP_W-1:0]     op_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*2*OP_W-1:0]   product
);

    localparam int N     = OP_W / CHUNK_W;
    localparam int PW    = 2 * OP_W;
    localparam int PPW   = 2 * CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] i_idx, j_idx;
    logic [OP_W-1:0]  mag_a [LANES];
    logic [OP_W-1:0]  mag_b [LANES];
    logic [LANES-1:0] neg;
    logic [PW-1:0]    acc [LANES];
    logic [PW-1:0]    prod_q [LANES];

    logic [OP_W-1:0]  mag_a_in [LANES];
    logic [OP_W-1:0]  mag_b_in [LANES];
    logic [LANES-1:0] neg_in;
    logic [PPW-1:0]   pp [LANES];
    logic [PW-1:0]    acc_sum [LANES];

    logic a_signed, b_signed, last_pair, accept, zero_skip;
    int   shamt;

    assign a_signed  = (mode == 2'b01) || (mode == 2'b10);
    assign b_signed  = (mode == 2'b01);
    assign last_pair = (i_idx == IDX_LAST) && (j_idx == IDX_LAST);
    assign accept    = in_valid && in_ready;
    assign shamt     = (int'(i_idx) + int'(j_idx)) * CHUNK_W;

`ifdef MUL_SEQ_ZERO_SKIP_EN
    logic all_zero;

    // Zero shortcut only applies when every lane would produce zero.
    always_comb begin
        all_zero = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if ((op_a[l*OP_W +: OP_W] != '0) && (op_b[l*OP_W +: OP_W] != '0))
                all_zero = 1'b0;
        end
    end
    assign zero_skip = all_zero;
`else
    assign zero_skip = 1'b0;
`endif

    // Strip signs from incoming operands; unsigned operands pass through as-is.
    always_comb begin
        neg_in = '0;
        for (int l = 0; l < LANES; l++) begin
            mag_a_in[l] = op_a[l*OP_W +: OP_W];
            mag_b_in[l] = op_b[l*OP_W +: OP_W];
            if (a_signed && op_a[l*OP_W + OP_W - 1])
                mag_a_in[l] = -op_a[l*OP_W +: OP_W];
            if (b_signed && op_b[l*OP_W + OP_W - 1])
                mag_b_in[l] = -op_b[l*OP_W +: OP_W];
            neg_in[l] = (a_signed && op_a[l*OP_W + OP_W - 1])
                      ^ (b_signed && op_b[l*OP_W + OP_W - 1]);
        end
    end

    // Current chunk product per lane, shifted into place and added to the accumulator.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pp[l]      = PPW'(mag_a[l][int'(i_idx)*CHUNK_W +: CHUNK_W])
                       * PPW'(mag_b[l][int'(j_idx)*CHUNK_W +: CHUNK_W]);
            acc_sum[l] = acc[l] + (PW'(pp[l]) << shamt);
        end
    end

    // Pack lane results onto the output bus.
    always_comb begin
        product = '0;
        for (int l = 0; l < LANES; l++)
            product[l*PW +: PW] = prod_q[l];
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = zero_skip ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (last_pair)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Operand latching, chunk iteration and accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_idx <= '0;
            j_idx <= '0;
            neg   <= '0;
            for (int l = 0; l < LANES; l++) begin
                mag_a[l]  <= '0;
                mag_b[l]  <= '0;
                acc[l]    <= '0;
                prod_q[l] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        neg   <= neg_in;
                        for (int l = 0; l < LANES; l++) begin
                            mag_a[l] <= mag_a_in[l];
                            mag_b[l] <= mag_b_in[l];
                            acc[l]   <= '0;
                            if (zero_skip)
                                prod_q[l] <= '0;
                        end
                    end
                end
                S_CALC: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc[l] <= acc_sum[l];
                        if (last_pair)
                            prod_q[l] <= neg[l] ? -acc_sum[l] : acc_sum[l];
                    end
                    if (j_idx == IDX_LAST) begin
                        j_idx <= '0;
                        i_idx <= i_idx + IDX_W'(1);
                    end else begin
                        j_idx <= j_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_lanes.sv
// Self-checking bench for mul_seq_lanes with default parameters
// (2 lanes, 16-bit operands, 8-bit chunks). Expected products come from
// plain signed/unsigned 64-bit arithmetic on the operands.
module tb_mul_seq_lanes;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    localparam int NOM_LAT = 4;

    mul_seq_lanes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        longint av, bv;
        av = (m == 2'b01 || m == 2'b10) ? longint'($signed(a)) : longint'(a);
        bv = (m == 2'b01) ? longint'($signed(b)) : longint'(b);
        return 32'(av * bv);
    endfunction

    function automatic int exp_lat(input logic [15:0] a0, input logic [15:0] b0,
                                   input logic [15:0] a1, input logic [15:0] b1);
`ifdef MUL_SEQ_ZERO_SKIP_EN
        if ((a0 == 0 || b0 == 0) && (a1 == 0 || b1 == 0))
            return 1;
`endif
        return NOM_LAT;
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Entered #1 after a posedge with the DUT idle; leaves it idle again.
    task automatic do_op(input logic [1:0] m, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1,
                         output int lat, output logic [63:0] prod);
        mode     = m;
        op_a     = {a1, a0};
        op_b     = {b1, b0};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode     = 2'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        prod = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'b00; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_m  [3] = '{2'b00, 2'b01, 2'b10};
        logic [15:0] t_a0 [3] = '{16'h5678, 16'hFFFF, 16'hFFFE};
        logic [15:0] t_b0 [3] = '{16'h1234, 16'h0002, 16'hFFFF};
        logic [15:0] t_a1 [3] = '{16'hFFFF, 16'h8000, 16'h0003};
        logic [15:0] t_b1 [3] = '{16'h0002, 16'h8000, 16'hFFFF};
        logic [31:0] t_p0 [3] = '{32'h06260060, 32'hFFFFFFFE, 32'hFFFE0002};
        logic [31:0] t_p1 [3] = '{32'h0001FFFE, 32'h40000000, 32'h0002FFFD};
        int lat;
        logic [63:0] p;
        for (int t = 0; t < 3; t++) begin
            do_op(t_m[t], t_a0[t], t_b0[t], t_a1[t], t_b1[t], lat, p);
            checks++; if (lat !== NOM_LAT) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", t, lat, NOM_LAT); end
            checks++; if (p[31:0] !== t_p0[t]) begin errors++; $display("FAIL directed%0d_lane0: got %h expected %h", t, p[31:0], t_p0[t]); end
            checks++; if (p[63:32] !== t_p1[t]) begin errors++; $display("FAIL directed%0d_lane1: got %h expected %h", t, p[63:32], t_p1[t]); end
        end
    endtask

    task automatic test_random();
        int lat, elat;
        logic [63:0] p;
        logic [1:0]  m;
        logic [15:0] a0, b0, a1, b1;
        for (int t = 0; t < 24; t++) begin
            m  = 2'($urandom_range(0, 3));
            a0 = pick_operand(); b0 = pick_operand();
            a1 = pick_operand(); b1 = pick_operand();
            elat = exp_lat(a0, b0, a1, b1);
            do_op(m, a0, b0, a1, b1, lat, p);
            checks++; if (lat !== elat) begin errors++; $display("FAIL random%0d_latency: got %0d expected %0d", t, lat, elat); end
            checks++; if (p[31:0] !== ref_mul(m, a0, b0)) begin errors++; $display("FAIL random%0d_lane0 m=%0d a=%h b=%h: got %h expected %h", t, m, a0, b0, p[31:0], ref_mul(m, a0, b0)); end
            checks++; if (p[63:32] !== ref_mul(m, a1, b1)) begin errors++; $display("FAIL random%0d_lane1 m=%0d a=%h b=%h: got %h expected %h", t, m, a1, b1, p[63:32], ref_mul(m, a1, b1)); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp1, exp2;
        int lat;
        exp1 = {ref_mul(2'b00, 16'hBEEF, 16'h1357), ref_mul(2'b00, 16'h1234, 16'hCAFE)};
        exp2 = {ref_mul(2'b01, 16'h9ABC, 16'h7001), ref_mul(2'b01, 16'h8001, 16'hF00D)};
        mode = 2'b00; op_a = {16'hBEEF, 16'h1234}; op_b = {16'h1357, 16'hCAFE};
        in_valid = 1'b1;
        @(posedge clk); #1;
        mode = 2'b01; op_a = {16'h9ABC, 16'h8001}; op_b = {16'h7001, 16'hF00D};
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_in_ready: got %b expected 0", in_ready); end
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = c; break; end
        end
        checks++; if (lat !== NOM_LAT) begin errors++; $display("FAIL bp_first_latency: got %0d expected %0d", lat, NOM_LAT); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_out_valid: got %b expected 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_in_ready: got %b expected 0", c, in_ready); end
            checks++; if (product !== exp1) begin errors++; $display("FAIL bp_hold%0d_product: got %h expected %h", c, product, exp1); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        checks++; if (product !== exp1) begin errors++; $display("FAIL bp_release_product_hold: got %h expected %h", product, exp1); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: in_ready got %b expected 0", in_ready); end
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = c; break; end
        end
        checks++; if (lat !== NOM_LAT) begin errors++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, NOM_LAT); end
        checks++; if (product !== exp2) begin errors++; $display("FAIL bp_second_product: got %h expected %h", product, exp2); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [63:0] p;
        mode = 2'b01; op_a = {16'h4321, 16'hF123}; op_b = {16'h0777, 16'h8765};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 64'h0) begin errors++; $display("FAIL midrst_product: got %h expected 0", product); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat = c;
        end
        checks++; if (lat !== 0) begin errors++; $display("FAIL midrst_no_emit: out_valid seen at cycle %0d expected never", lat); end
        do_op(2'b10, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, lat, p);
        checks++; if (lat !== NOM_LAT) begin errors++; $display("FAIL midrst_after_latency: got %0d expected %0d", lat, NOM_LAT); end
        checks++; if (p !== {ref_mul(2'b10, 16'h7FFF, 16'h8000), ref_mul(2'b10, 16'h8000, 16'hFFFF)}) begin
            errors++; $display("FAIL midrst_after_product: got %h expected %h", p, {ref_mul(2'b10, 16'h7FFF, 16'h8000), ref_mul(2'b10, 16'h8000, 16'hFFFF)});
        end
    endtask

    task automatic test_zero();
        int lat, elat;
        logic [63:0] p;
        logic [15:0] b0, b1;
        b0 = 16'($urandom_range(1, 65535));
        b1 = 16'($urandom_range(1, 65535));
        elat = exp_lat(16'h0, b0, 16'h0, b1);
        do_op(2'b01, 16'h0000, b0, 16'h0000, b1, lat, p);
        checks++; if (lat !== elat) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, elat); end
        checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_product: got %h expected 0", p); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
